fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the byte address of the first instruction fetched after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port imem_req  output  1  SHALL signal a fetch request to instruction memory.
REQ-005 Port imem_addr  output  32  SHALL carry the byte address of the requested word; low 2 bits always 0.
REQ-006 Port imem_ready  input  1  SHALL mark imem_rdata valid in the same cycle.
REQ-007 Port imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-008 Port instr  output  32  SHALL carry the held instruction to the decoder/controller (op = instr[31:26], func = instr[5:0]).
REQ-009 Port instr_valid  output  1  SHALL mark instr, pc and pc_plus4 valid for execution.
REQ-010 Port instr_accept  input  1  SHALL mark the current instruction as retired, with pcsel and jr_target valid.
REQ-011 Port pcsel  input  2  SHALL select the next PC: 00 sequential, 01 branch taken, 10 J/JAL, 11 JR.
REQ-012 Port jr_target  input  32  SHALL carry register rs for JR.
REQ-013 Port pc  output  32  SHALL carry the address of the held instruction.
REQ-014 Port pc_plus4  output  32  SHALL carry pc + 4, used as the JAL link value.
REQ-015 Port misalign  output  1  SHALL pulse for one cycle when a JR target has nonzero low bits.

Function
REQ-016 States SHALL be IDLE, REQ, and HOLD.
REQ-017 IDLE: imem_req=0, instr_valid=0; unconditional transition to REQ on the next edge.
REQ-018 REQ: imem_req=1, imem_addr=pc; imem_req stays high, with imem_addr stable, until imem_ready=1.
REQ-019 REQ with imem_ready=1 at a rising edge: instr <= imem_rdata, then transition to HOLD.
REQ-020 Minimum fetch latency: instr_valid SHALL rise one cycle after the cycle in which imem_req and imem_ready are both high.
REQ-021 HOLD: instr_valid=1, imem_req=0; instr and pc SHALL stay stable until instr_accept=1.
REQ-022 HOLD with instr_accept=1 at an edge: pc <= next_pc, then transition to REQ; instr_valid drops the next cycle.
REQ-023 next_pc for pcsel 00 SHALL be pc+4.
REQ-024 next_pc for pcsel 01 SHALL be pc+4 + (sign-extended instr[15:0] << 2).
REQ-025 next_pc for pcsel 10 SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-026 next_pc for pcsel 11 SHALL be {jr_target[31:2], 2'b00}.
REQ-027 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, and branch offsets wrap likewise.
REQ-028 pcsel=11 with jr_target[1:0] != 0 on an accepting edge SHALL assert misalign for exactly the following cycle and SHALL still jump to the aligned address.
REQ-029 instr_accept in IDLE or REQ SHALL be ignored.
REQ-030 pcsel and jr_target SHALL be sampled only on the accepting edge.
REQ-031 imem_ready in IDLE or HOLD SHALL be ignored; no capture, no state change.
REQ-032 pc_plus4 SHALL be derived combinationally from pc at all times.

Reset
REQ-033 reset=1 at an edge SHALL force: state=IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, misalign=0.
REQ-034 reset asserted in REQ or HOLD SHALL abandon the pending fetch or instruction; any imem_ready arriving in the same cycle SHALL be discarded.
REQ-035 Reset SHALL take priority over all simultaneous events.
REQ-036 After release, the first imem_req SHALL assert in the second cycle (IDLE then REQ), with imem_addr=RESET_PC.

Verification
REQ-037 Reset then sequential fetch: release reset; imem_ready=1 immediately; accept with pcsel=00 each time -> imem_addr sequence 0x0, 0x4, 0x8; each instr_valid rises one cycle after its capture.
REQ-038 Memory wait states: imem_ready held low 3 cycles at pc=0x40 -> imem_req and imem_addr=0x40 stable for 4 cycles; instr captured only on the ready cycle.
REQ-039 Branch backward: pc=0x100, instr[15:0]=16'hFFFC, pcsel=01 accepted -> next imem_addr=0xF4.
REQ-040 Jump and JR: pc=0x1000_0010 with instr[25:0]=26'h000_0040, pcsel=10 -> next imem_addr 0x1000_0100; then pcsel=11 with jr_target=0x0000_2003 -> imem_addr 0x2000, misalign pulses exactly 1 cycle.
REQ-041 Wrap-around: RESET_PC=0xFFFF_FFFC, pcsel=00 accepted -> next imem_addr=0x0 and pc_plus4 read 0x0 while pc was 0xFFFF_FFFC.
REQ-042 Reset mid-operation: assert reset during HOLD with instr_accept=1, and again during REQ with imem_ready=1 -> pc=RESET_PC, instr_valid=0, no capture; normal fetch from RESET_PC resumes.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for the decoder, and computes the next PC on retirement.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic [1:0]  pcsel,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        misalign_q;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_off;
    logic [31:0] next_pc_d;

    assign pc_plus4_w = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        // NOTE: assign a default before the case so every path drives next_pc_d and no latch is inferred.
        next_pc_d = pc_plus4_w;
        case (pcsel)
            2'b01:   next_pc_d = pc_plus4_w + branch_off;
            2'b10:   next_pc_d = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
            2'b11:   next_pc_d = {jr_target[31:2], 2'b00};
            default: next_pc_d = pc_plus4_w;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            instr_q    <= 32'h0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_accept) begin
                        pc_q       <= next_pc_d;
                        state_q    <= REQ;
                        req_q      <= 1'b1;
                        valid_q    <= 1'b0;
                        misalign_q <= (pcsel == 2'b11) && (jr_target[1:0] != 2'b00);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses and
// misalign pulses; a negedge monitor pops and compares against DUT activity.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_accept = 1'b0;
    logic [1:0]  pcsel = 2'b00;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    logic        w_reset = 1'b1;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ready = 1'b0;
    logic [31:0] w_instr;
    logic        w_valid;
    logic        w_accept = 1'b0;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_misalign;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_accept(instr_accept),
        .pcsel(pcsel), .jr_target(jr_target),
        .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(w_reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(w_ready), .imem_rdata(32'h0),
        .instr(w_instr), .instr_valid(w_valid), .instr_accept(w_accept),
        .pcsel(2'b00), .jr_target(32'h0),
        .pc(w_pc), .pc_plus4(w_pc_plus4), .misalign(w_misalign)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] addr_q[$];
    bit          mis_q[$];
    logic [31:0] dir_mem[logic [31:0]];
    logic [31:0] cur_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: DUT event did not occur within bound at %0t", name, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (dir_mem.exists(a)) return dir_mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    // Architectural next-PC rules written with plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cpc, input logic [31:0] ins,
                                               input logic [1:0] sel, input logic [31:0] jr);
        logic [31:0] seq;
        int          off;
        seq = cpc + 32'd4;
        off = int'($signed(ins[15:0]));
        case (sel)
            2'd0:    return seq;
            2'd1:    return seq + 32'(off * 4);
            2'd2:    return (seq & 32'hF000_0000) + (ins & 32'h03FF_FFFF) * 32'd4;
            default: return jr & ~32'h3;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_ready = 1'b0;
        instr_accept = 1'b0;
        step();
        step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instr, 32'h0);
        addr_q.delete();
        mis_q.delete();
        cur_pc = RST_PC;
        addr_q.push_back(RST_PC);
        reset = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        check("idle_req", 32'(imem_req), 32'd0);
        step();
        imem_ready = 1'b0;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RST_PC);
    endtask

    task automatic do_fetch(input int waits);
        int t = 0;
        while (!imem_req && t < 20) begin step(); t++; end
        if (!imem_req) begin timeout_fail("req_timeout"); return; end
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            instr_accept = 1'($urandom_range(0, 1));
            pcsel = 2'($urandom);
            step();
        end
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
        instr_accept = 1'($urandom_range(0, 1));
        step();
        imem_ready = 1'b0;
        instr_accept = 1'b0;
    endtask

    task automatic do_accept(input int idle, input logic [1:0] sel, input logic [31:0] jr);
        int          t = 0;
        logic [31:0] nxt;
        while (!instr_valid && t < 20) begin step(); t++; end
        if (!instr_valid) begin timeout_fail("valid_timeout"); return; end
        for (int i = 0; i < idle; i++) begin
            instr_accept = 1'b0;
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            pcsel = 2'($urandom);
            jr_target = $urandom;
            step();
        end
        instr_accept = 1'b1;
        pcsel = sel;
        jr_target = jr;
        imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        nxt = model_next(cur_pc, mem_word(cur_pc), sel, jr);
        addr_q.push_back(nxt);
        mis_q.push_back(sel == 2'd3 && jr[1:0] != 2'b00);
        cur_pc = nxt;
        step();
        instr_accept = 1'b0;
        imem_ready = 1'b0;
        pcsel = 2'($urandom);
        jr_target = $urandom;
    endtask

    // Monitor: compares every DUT-visible event against scoreboard expectations.
    logic [31:0] held_pc = 32'h0;
    logic [31:0] held_instr = 32'h0;
    bit          pend = 1'b0;
    bit          acc_prev = 1'b0;

    always @(negedge clk) begin
        bit exp_m;
        if (reset) begin
            pend = 1'b0;
            acc_prev = 1'b0;
        end else begin
            exp_m = 1'b0;
            if (acc_prev) exp_m = (mis_q.size() > 0) ? mis_q.pop_front() : 1'b0;
            check("misalign", 32'(misalign), 32'(exp_m));
            if (pend) begin
                check("fetch_latency", 32'(instr_valid), 32'd1);
                pend = 1'b0;
            end
            if (instr_valid) begin
                check("instr", instr, held_instr);
                check("pc", pc, held_pc);
                check("pc_plus4", pc_plus4, held_pc + 32'd4);
            end
            if (imem_req) begin
                check("req_excl_valid", 32'(instr_valid), 32'd0);
                if (addr_q.size() == 0) begin
                    timeout_fail("unexpected_req");
                end else begin
                    check("imem_addr", imem_addr, addr_q[0]);
                    if (imem_ready) begin
                        held_pc = addr_q.pop_front();
                        held_instr = mem_word(held_pc);
                        pend = 1'b1;
                    end
                end
            end
            acc_prev = instr_valid && instr_accept;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        dir_mem[32'h0000_0100] = 32'h1000_FFFC;
        dir_mem[32'h1000_0010] = 32'h0800_0040;
        cur_pc = RST_PC;

        // Wrap-around instance with RESET_PC at the top of the address space.
        step();
        step();
        check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        w_reset = 1'b0;
        step();
        check("wrap_req", 32'(w_req), 32'd1);
        check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        check("wrap_pc_plus4_req", w_pc_plus4, 32'h0);
        w_ready = 1'b1;
        step();
        w_ready = 1'b0;
        check("wrap_valid", 32'(w_valid), 32'd1);
        check("wrap_pc_plus4_hold", w_pc_plus4, 32'h0);
        w_accept = 1'b1;
        step();
        w_accept = 1'b0;
        check("wrap_next_req", 32'(w_req), 32'd1);
        check("wrap_next_addr", w_addr, 32'h0);

        do_reset();
        repeat (3) begin
            do_fetch(0);
            do_accept(0, 2'd0, 32'h0);
        end
        check("seq_addr", imem_addr, 32'hC);

        do_fetch(0);
        do_accept(0, 2'd3, 32'h40);
        check("wait_addr", imem_addr, 32'h40);
        do_fetch(3);

        do_accept(1, 2'd3, 32'h100);
        do_fetch(1);
        do_accept(0, 2'd1, 32'h0);
        check("branch_back", imem_addr, 32'hF4);

        do_fetch(0);
        do_accept(0, 2'd3, 32'h1000_0010);
        do_fetch(2);
        do_accept(0, 2'd2, 32'h0);
        check("jump", imem_addr, 32'h1000_0100);

        do_fetch(0);
        do_accept(0, 2'd3, 32'h0000_2003);
        check("jr_addr", imem_addr, 32'h2000);
        check("misalign_pulse", 32'(misalign), 32'd1);
        imem_ready = 1'b0;
        step();
        check("misalign_once", 32'(misalign), 32'd0);

        do_fetch(0);
        do_accept(0, 2'd3, 32'hFFFF_FFFC);
        do_fetch(0);
        check("wrap_pc_main", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4_main", pc_plus4, 32'h0);
        do_accept(0, 2'd0, 32'h0);
        check("wrap_addr_main", imem_addr, 32'h0);

        // Reset during HOLD with an accept on the same edge.
        do_fetch(0);
        reset = 1'b1;
        instr_accept = 1'b1;
        pcsel = 2'b11;
        jr_target = 32'h0000_0403;
        step();
        instr_accept = 1'b0;
        check("rst_hold_pc", pc, RST_PC);
        check("rst_hold_valid", 32'(instr_valid), 32'd0);
        check("rst_hold_misalign", 32'(misalign), 32'd0);
        do_reset();

        // Reset during REQ with imem_ready on the same edge.
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ready = 1'b0;
        check("rst_req_instr", instr, 32'h0);
        check("rst_req_valid", 32'(instr_valid), 32'd0);
        check("rst_req_req", 32'(imem_req), 32'd0);
        do_reset();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            do_fetch(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
            do_accept(int'($urandom_range(0, 2)), 2'($urandom), $urandom);
        end

        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
